incr_stream: RTL and testbench

INCR_STREAM -- requirements
Module: incr_stream

---
 rtl/incr_stream.sv | 90 +++++++++
 tb/tb_incr_stream.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/incr_stream.sv
// Streaming WIDTH-bit incrementer with per-beat wrap/saturate mode, a small
// result FIFO, and a saturating count of overflowing beats.
module incr_stream #(
    parameter int WIDTH  = 70,
    parameter int STEP_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset_l,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [STEP_W-1:0] in_step,
    input  logic              in_sat,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_ovf,
    output logic [15:0]       ovf_cnt,
    input  logic              cnt_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH:0]   mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             rdy_en;
    logic [WIDTH:0]   sum;
    logic             ovf;
    logic [WIDTH-1:0] result;
    logic             push;
    logic             pop;

    assign sum    = {1'b0, in_data} + {{(WIDTH+1-STEP_W){1'b0}}, in_step};
    assign ovf    = sum[WIDTH];
    assign result = (in_sat && ovf) ? '1 : sum[WIDTH-1:0];

    // rdy_en keeps in_ready low until the first edge after reset release;
    // in_ready depends only on registered state, never on out_ready.
    assign in_ready  = rdy_en && (count < FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Storage is not reset, so the head is masked while the FIFO is empty.
    assign out_data = out_valid ? mem[rd_ptr][WIDTH:1] : '0;
    assign out_ovf  = out_valid ? mem[rd_ptr][0]       : 1'b0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {result, ovf};
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            rdy_en <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            ovf_cnt <= '0;
        end else if (cnt_clr) begin
            ovf_cnt <= (push && ovf) ? 16'd1 : 16'd0;
        end else if (push && ovf && (ovf_cnt != 16'hFFFF)) begin
            ovf_cnt <= ovf_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_incr_stream.sv
// Scoreboard bench for incr_stream: expected beats are queued at acceptance
// and compared against the FIFO head every cycle.
module tb_incr_stream;

    localparam int W = 70;
    localparam int S = 8;
    localparam int D = 4;

    logic          clk = 1'b0;
    logic          reset_l;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [S-1:0]  in_step;
    logic          in_sat;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_ovf;
    logic [15:0]   ovf_cnt;
    logic          cnt_clr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W:0]  sb_q [$];
    logic        m_rdy_en;
    logic [15:0] m_cnt;
    logic [W-1:0] all1;

    incr_stream #(.WIDTH(W), .STEP_W(S), .DEPTH(D)) dut (
        .clk       (clk),
        .reset_l   (reset_l),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_step   (in_step),
        .in_sat    (in_sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .ovf_cnt   (ovf_cnt),
        .cnt_clr   (cnt_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W:0] calc(input logic [W-1:0] d, input logic [S-1:0] s, input logic sat);
        logic [W:0] sm;
        logic [W-1:0] r;
        sm = {1'b0, d} + {{(W+1-S){1'b0}}, s};
        r  = (sat && sm[W]) ? {W{1'b1}} : sm[W-1:0];
        return {r, sm[W]};
    endfunction

    // Reference model: acceptance decided from the model's own occupancy.
    always @(posedge clk or negedge reset_l) begin
        logic acc;
        logic [W:0] e;
        if (!reset_l) begin
            sb_q.delete();
            m_rdy_en = 1'b0;
            m_cnt    = '0;
        end else begin
            acc = in_valid && m_rdy_en && (sb_q.size() < D);
            e   = calc(in_data, in_step, in_sat);
            if (out_ready && sb_q.size() > 0) void'(sb_q.pop_front());
            if (acc) sb_q.push_back(e);
            if (cnt_clr) m_cnt = (acc && e[0]) ? 16'd1 : 16'd0;
            else if (acc && e[0] && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            m_rdy_en = 1'b1;
        end
    end

    always @(negedge clk) begin
        chk("in_ready", in_ready, m_rdy_en && (sb_q.size() < D));
        chk("out_valid", out_valid, sb_q.size() != 0);
        chk("ovf_cnt", ovf_cnt, m_cnt);
        if (sb_q.size() != 0) begin
            chk("out_data", out_data, sb_q[0][W:1]);
            chk("out_ovf", out_ovf, sb_q[0][0]);
        end else begin
            chk("out_data_idle", out_data, 0);
        end
    end

    task automatic drive(input logic v, input logic [W-1:0] d, input logic [S-1:0] s, input logic sat);
        @(posedge clk); #1;
        in_valid = v;
        in_data  = d;
        in_step  = s;
        in_sat   = sat;
    endtask

    initial begin
        all1      = '1;
        reset_l   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_step   = '0;
        in_sat    = 1'b0;
        out_ready = 1'b0;
        cnt_clr   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ovf_cnt", ovf_cnt, 0);
        @(negedge clk); #1;
        reset_l = 1'b1;
        #1 chk("rel_in_ready_low", in_ready, 0);
        @(negedge clk);
        chk("rel_in_ready_high", in_ready, 1);

        // wrap
        out_ready = 1'b1;
        drive(1, 70'h3F_FFFF_FFFF_FFFF_FFFF, 1, 0);
        drive(0, '0, 0, 0);
        @(negedge clk);
        chk("wrap_data", out_data, 0);
        chk("wrap_ovf", out_ovf, 1);
        chk("wrap_cnt", ovf_cnt, 1);

        // saturate, then a non-overflowing saturate-mode beat
        drive(1, all1 - 70'd2, 5, 1);
        drive(1, 70'd10, 3, 1);
        @(negedge clk);
        chk("sat_data", out_data, all1);
        chk("sat_ovf", out_ovf, 1);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("nosat_data", out_data, 13);
        chk("nosat_ovf", out_ovf, 0);

        // backpressure: fill the FIFO, then a single pop
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int i = 0; i < D; i++) drive(1, 70'd100 + 70'(i), 8'(i), 0);
        drive(0, '0, 0, 0);
        @(negedge clk);
        chk("bp_full_in_ready", in_ready, 0);
        chk("bp_head", out_data, 100);
        repeat (2) @(negedge clk);
        chk("bp_hold", out_data, 100);
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        chk("bp_in_ready_back", in_ready, 1);
        chk("bp_order", out_data, 102);
        @(posedge clk); #1 out_ready = 1'b1;
        repeat (5) @(posedge clk);

        // streaming with mixed modes
        for (int i = 0; i < 24; i++) begin
            drive(1, {$urandom, $urandom, $urandom} | ((i % 3 == 0) ? all1 - 70'd4 : 70'd0),
                  8'($urandom), 1'($urandom));
            if (i > 0) begin
                @(negedge clk);
                chk("stream_valid", out_valid, 1);
            end
        end
        drive(0, '0, 0, 0);

        // counter saturation then clear coincident with an overflow
        @(posedge clk); #1 cnt_clr = 1'b1;
        @(posedge clk); #1 cnt_clr = 1'b0;
        drive(1, all1, 1, 0);
        repeat (65540) @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("cnt_sat", ovf_cnt, 16'hFFFF);
        drive(1, all1, 2, 0);
        #0 cnt_clr = 1'b1;
        drive(0, '0, 0, 0);
        cnt_clr = 1'b0;
        @(negedge clk);
        chk("cnt_clr_ovf", ovf_cnt, 1);
        repeat (3) @(posedge clk);

        // reset with three beats buffered
        #1 out_ready = 1'b0;
        for (int i = 0; i < 3; i++) drive(1, 70'd50 + 70'(i), 1, 0);
        drive(0, '0, 0, 0);
        @(negedge clk);
        chk("mid_buffered", out_valid, 1);
        #2 reset_l = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_cnt", ovf_cnt, 0);
        @(negedge clk); #1 reset_l = 1'b1;
        out_ready = 1'b1;
        #1 chk("mid_rel_in_ready_low", in_ready, 0);
        @(negedge clk);
        chk("mid_rel_in_ready", in_ready, 1);
        repeat (3) @(negedge clk);
        chk("mid_no_stale", out_valid, 0);
        drive(1, 70'd7, 9, 1);
        drive(0, '0, 0, 0);
        @(negedge clk);
        chk("mid_new_beat", out_data, 16);
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
